// File: rtl/l2_ddr_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_ddr_refill_ctrl_pkg
// Description : Shared types and constants for the L2 refill-from-DDR path.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_ddr_refill_ctrl_pkg;

  // Refill FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } refill_state_t;

  localparam int          c_DDR_BEAT_W     = 128;
  localparam int          c_L2_WORD_W      = 16;
  localparam logic [11:0] c_L2_SIZE_WORDS  = 12'hFFF;
  localparam int          c_WORDS_PER_BEAT = c_DDR_BEAT_W / c_L2_WORD_W;

endpackage : l2_ddr_refill_ctrl_pkg
`default_nettype wire

// File: rtl/l2_refill_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l2_refill_beat_fifo
// Description : Small synchronous FIFO holding DDR beats awaiting an L2 write
//               slot. DEPTH must be a power of two (pointers wrap naturally).
// Revision    : 1.0 - initial release
// ============================================================================
module l2_refill_beat_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_CNT_W = c_AW + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               w_pop_ok;
  logic               w_push_ok;

  // Guarded push/pop and next pointer/occupancy values
  always_comb begin
    w_pop_ok  = i_pop & (count_q != '0);
    w_push_ok = i_push & ((count_q != c_FULL) | w_pop_ok);
    wr_ptr_d  = wr_ptr_q + c_AW'(w_push_ok);
    rd_ptr_d  = rd_ptr_q + c_AW'(w_pop_ok);
    count_d   = count_q + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop_ok);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Beat storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule : l2_refill_beat_fifo
`default_nettype wire

// File: rtl/l2_ddr_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l2_ddr_refill_ctrl
// Description : Issues DDR burst reads when L2 runs low and streams returned
//               beats into L2 port B, holding them back during L1/DDR
//               port conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_ddr_refill_ctrl
  import l2_ddr_refill_ctrl_pkg::*;
#(
  parameter int          BURST_BEATS   = 8,
  parameter logic [11:0] LOW_WATERMARK = 12'd1024
) (
  input  logic                    clk_166M66,
  input  logic                    mcu_sys_rst_n,
  input  logic                    i_refill_enable,
  input  logic [23:0]             i_ddr_base_address,
  input  logic [11:0]             i_l2_unread_size,
  input  logic                    i_l1ddr_rw_confilicts,
  output logic                    o_ddr_rd_req,
  output logic [23:0]             o_ddr_rd_addr,
  input  logic                    i_ddr_rd_ack,
  input  logic                    i_ddr_rd_valid,
  input  logic [c_DDR_BEAT_W-1:0] i_ddr_rd_data,
  output logic                    o_l2_ddr_operate_enable,
  output logic                    o_l2_ddr_rw,
  output logic [c_DDR_BEAT_W-1:0] o_l2_ddr_data,
  output logic                    o_busy,
  output logic                    o_protocol_err,
  output logic [15:0]             o_beats_written
);

  localparam int                c_CW        = $clog2(BURST_BEATS) + 1;
  localparam logic [c_CW-1:0]   c_CNT_ONE   = c_CW'(1);
  localparam logic [c_CW-1:0]   c_CNT_LAST  = c_CW'(BURST_BEATS - 1);
  localparam logic [23:0]       c_ADDR_STEP = 24'(BURST_BEATS);
  localparam logic [12:0]       c_MIN_FREE  = 13'(BURST_BEATS * c_WORDS_PER_BEAT);

  refill_state_t           state_q, state_d;
  logic [23:0]             addr_q, addr_d;
  logic                    en_prev_q, en_prev_d;
  logic                    rd_req_q, rd_req_d;
  logic [c_CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;
  logic                    wr_en_q, wr_en_d;
  logic [c_DDR_BEAT_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]             beats_written_q, beats_written_d;

  logic                    w_beat_in;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_start_ok;
  logic [12:0]             w_free;
  logic [c_DDR_BEAT_W-1:0] w_fifo_head;
  logic                    w_fifo_empty;
  logic [c_CW-1:0]         w_fifo_count;

  l2_refill_beat_fifo #(
    .DEPTH (BURST_BEATS),
    .WIDTH (c_DDR_BEAT_W)
  ) u_beat_fifo (
    .clk         (clk_166M66),
    .rst_n       (mcu_sys_rst_n),
    .i_push      (w_push),
    .i_push_data (i_ddr_rd_data),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Next-state, L2 write-port and FIFO control
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_cnt_d      = beat_cnt_q;
    en_prev_d       = i_refill_enable;
    w_free          = {1'b0, c_L2_SIZE_WORDS} - {1'b0, i_l2_unread_size};
    w_start_ok      = i_refill_enable && (i_l2_unread_size <= LOW_WATERMARK) &&
                      (w_free >= c_MIN_FREE) && w_fifo_empty;
    w_beat_in       = i_ddr_rd_valid && (state_q == ST_RECV);
    // Beats arriving in any other state are dropped and flagged
    err_d           = err_q | (i_ddr_rd_valid && (state_q != ST_RECV));

    // Older FIFO beats always go first; an empty FIFO lets a new beat bypass
    // straight to the output register for single-cycle latency.
    w_push          = w_beat_in;
    w_pop           = 1'b0;
    wr_en_d         = 1'b0;
    wr_data_d       = wr_data_q;
    if (!i_l1ddr_rw_confilicts) begin
      if (!w_fifo_empty) begin
        wr_en_d   = 1'b1;
        wr_data_d = w_fifo_head;
        w_pop     = 1'b1;
      end else if (w_beat_in) begin
        wr_en_d   = 1'b1;
        wr_data_d = i_ddr_rd_data;
        w_push    = 1'b0;
      end
    end
    beats_written_d = beats_written_q + 16'(wr_en_d);

    case (state_q)
      ST_IDLE: begin
        if (i_refill_enable && !en_prev_q) begin
          addr_d = i_ddr_base_address;
        end
        if (w_start_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_ddr_rd_ack) begin
          addr_d     = addr_q + c_ADDR_STEP;
          beat_cnt_d = '0;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_beat_in) begin
          beat_cnt_d = beat_cnt_q + c_CNT_ONE;
          if (beat_cnt_q == c_CNT_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_fifo_empty || ((w_fifo_count == c_CNT_ONE) && w_pop)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_req_d = (state_d == ST_REQ);
  end

  // All controller state and registered outputs
  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      en_prev_q       <= 1'b0;
      rd_req_q        <= 1'b0;
      beat_cnt_q      <= '0;
      err_q           <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_data_q       <= '0;
      beats_written_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      en_prev_q       <= en_prev_d;
      rd_req_q        <= rd_req_d;
      beat_cnt_q      <= beat_cnt_d;
      err_q           <= err_d;
      wr_en_q         <= wr_en_d;
      wr_data_q       <= wr_data_d;
      beats_written_q <= beats_written_d;
    end
  end

  assign o_ddr_rd_req            = rd_req_q;
  assign o_ddr_rd_addr           = addr_q;
  assign o_l2_ddr_operate_enable = wr_en_q;
  assign o_l2_ddr_rw             = wr_en_q;
  assign o_l2_ddr_data           = wr_data_q;
  assign o_busy                  = (state_q != ST_IDLE);
  assign o_protocol_err          = err_q;
  assign o_beats_written         = beats_written_q;

endmodule : l2_ddr_refill_ctrl
`default_nettype wire

// File: tb/tb_l2_ddr_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_ddr_refill_ctrl
// Description : Directed self-checking bench for l2_ddr_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_ddr_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [23:0]  base;
  logic [11:0]  unread;
  logic         conflict;
  logic         ack;
  logic         valid;
  logic [127:0] rdata;

  logic         req, op_en, rw, busy, perr;
  logic [23:0]  addr;
  logic [127:0] l2_data;
  logic [15:0]  bw;

  logic         req2, op_en2, rw2, busy2, perr2;
  logic [23:0]  addr2;
  logic [127:0] l2_data2;
  logic [15:0]  bw2;

  always #3 clk = ~clk;

  l2_ddr_refill_ctrl #(.BURST_BEATS(8), .LOW_WATERMARK(12'd1024)) dut (
    .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_refill_enable(en),
    .i_ddr_base_address(base), .i_l2_unread_size(unread),
    .i_l1ddr_rw_confilicts(conflict), .o_ddr_rd_req(req), .o_ddr_rd_addr(addr),
    .i_ddr_rd_ack(ack), .i_ddr_rd_valid(valid), .i_ddr_rd_data(rdata),
    .o_l2_ddr_operate_enable(op_en), .o_l2_ddr_rw(rw), .o_l2_ddr_data(l2_data),
    .o_busy(busy), .o_protocol_err(perr), .o_beats_written(bw)
  );

  // Second instance exercises the free-space limit with a high watermark
  l2_ddr_refill_ctrl #(.BURST_BEATS(8), .LOW_WATERMARK(12'hFFF)) dut_hiwm (
    .clk_166M66(clk), .mcu_sys_rst_n(rst_n), .i_refill_enable(en),
    .i_ddr_base_address(base), .i_l2_unread_size(unread),
    .i_l1ddr_rw_confilicts(conflict), .o_ddr_rd_req(req2), .o_ddr_rd_addr(addr2),
    .i_ddr_rd_ack(ack), .i_ddr_rd_valid(valid), .i_ddr_rd_data(rdata),
    .o_l2_ddr_operate_enable(op_en2), .o_l2_ddr_rw(rw2), .o_l2_ddr_data(l2_data2),
    .o_busy(busy2), .o_protocol_err(perr2), .o_beats_written(bw2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] wr_q[$];
  int           wr_cyc_q[$];
  logic [23:0]  req_q[$];
  int           req2_cnt  = 0;
  int           conf_viol = 0;
  int           rw_viol   = 0;
  logic         prev_conf = 1'b0;
  logic         prev_req  = 1'b0;
  logic         prev_req2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe L2 port B and DDR requests away from the active edge
  always @(negedge clk) begin
    if (op_en) begin
      wr_q.push_back(l2_data);
      wr_cyc_q.push_back(cyc);
    end
    if (rw !== op_en) rw_viol++;
    if (prev_conf && op_en) conf_viol++;
    prev_conf = conflict;
    if (req && !prev_req) req_q.push_back(addr);
    prev_req = req;
    if (req2 && !prev_req2) req2_cnt++;
    prev_req2 = req2;
  end

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; ack = 1'b0; valid = 1'b0; conflict = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Acts as the DDR controller for one burst
  task automatic do_burst(input int ack_dly, input int nbeats, input int conf_start,
                          input int conf_len, input logic drop_en, input logic [127:0] seed,
                          output int first_valid_cyc);
    int t = 0;
    first_valid_cyc = -1;
    while (!req && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("req_seen", 128'(req), 128'd1);
    if (req) begin
      repeat (ack_dly) begin @(posedge clk); #1; end
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      if (drop_en) en = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
        valid    = 1'b1;
        rdata    = seed + 128'(i);
        conflict = (i >= conf_start) && (i < conf_start + conf_len);
        if (i == 0) first_valid_cyc = cyc;
        @(posedge clk); #1;
      end
      valid = 1'b0; conflict = 1'b0; rdata = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fvc, w0, r0, r2;
    logic [127:0] seed;
    base = '0; unread = '0; en = 1'b0; conflict = 1'b0; ack = 1'b0; valid = 1'b0; rdata = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req",   128'(req),   128'd0);
    check_val("rst_addr",  128'(addr),  128'd0);
    check_val("rst_op_en", 128'(op_en), 128'd0);
    check_val("rst_busy",  128'(busy),  128'd0);
    check_val("rst_err",   128'(perr),  128'd0);
    check_val("rst_bw",    128'(bw),    128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: base 0x100, ack after 3 cycles, 8 back-to-back beats
    w0 = wr_q.size(); r0 = req_q.size();
    seed = 128'hA5A5_0000_0000_0000_0000_0000_0000_0100;
    unread = 12'd0; base = 24'h000100; en = 1'b1;
    do_burst(3, 8, 99, 0, 1'b1, seed, fvc);
    repeat (20) begin @(posedge clk); #1; end
    check_val("t1_req_cnt",  128'(req_q.size() - r0), 128'd1);
    if (req_q.size() > r0) check_val("t1_req_addr", 128'(req_q[r0]), 128'h000100);
    check_val("t1_wr_cnt",   128'(wr_q.size() - w0), 128'd8);
    for (int i = 0; i < 8 && (w0 + i) < wr_q.size(); i++)
      check_val($sformatf("t1_beat%0d", i), wr_q[w0 + i], seed + 128'(i));
    if (wr_cyc_q.size() > w0) check_val("t1_latency", 128'(wr_cyc_q[w0] - fvc), 128'd1);
    check_val("t1_bw",       128'(bw),   128'd8);
    check_val("t1_next_adr", 128'(addr), 128'h000108);
    check_val("t1_busy",     128'(busy), 128'd0);

    // Conflict held for 5 cycles mid-burst
    w0 = wr_q.size();
    seed = 128'hC0C0_0000_0000_0000_0000_0000_0000_0200;
    base = 24'h000200; en = 1'b1;
    do_burst(1, 8, 2, 5, 1'b1, seed, fvc);
    repeat (20) begin @(posedge clk); #1; end
    check_val("t2_conf_viol", 128'(conf_viol), 128'd0);
    check_val("t2_wr_cnt",    128'(wr_q.size() - w0), 128'd8);
    for (int i = 0; i < 8 && (w0 + i) < wr_q.size(); i++)
      check_val($sformatf("t2_beat%0d", i), wr_q[w0 + i], seed + 128'(i));
    check_val("t2_bw",  128'(bw),   128'd16);
    check_val("t2_err", 128'(perr), 128'd0);

    // Threshold and free-space limits
    r0 = req_q.size(); r2 = req2_cnt;
    unread = 12'h0FC0; en = 1'b1;
    repeat (30) begin @(posedge clk); #1; end
    check_val("t3_fc0_req",  128'(req_q.size() - r0), 128'd0);
    check_val("t3_fc0_req2", 128'(req2_cnt - r2),     128'd0);
    unread = 12'h0FB8;
    repeat (10) begin @(posedge clk); #1; end
    check_val("t3_fb8_req2", 128'(req2_cnt - r2),     128'd1);
    unread = 12'd1025;
    repeat (30) begin @(posedge clk); #1; end
    check_val("t3_1025_req", 128'(req_q.size() - r0), 128'd0);
    check_val("t3_busy",     128'(busy), 128'd0);

    // Address wrap across two consecutive bursts
    do_reset();
    r0 = req_q.size();
    unread = 12'd1024; base = 24'hFFFFF8; en = 1'b1;
    do_burst(2, 8, 99, 0, 1'b0, 128'h11, fvc);
    do_burst(2, 8, 99, 0, 1'b1, 128'h22, fvc);
    repeat (20) begin @(posedge clk); #1; end
    check_val("t4_req_cnt", 128'(req_q.size() - r0), 128'd2);
    if (req_q.size() > r0)     check_val("t4_addr0", 128'(req_q[r0]),     128'hFFFFF8);
    if (req_q.size() > r0 + 1) check_val("t4_addr1", 128'(req_q[r0 + 1]), 128'h000000);
    check_val("t4_next_adr", 128'(addr), 128'h000008);
    check_val("t4_bw",       128'(bw),   128'd16);

    // Unexpected beat while idle
    w0 = wr_q.size();
    valid = 1'b1; rdata = 128'hDEAD;
    @(posedge clk); #1;
    valid = 1'b0; rdata = '0;
    repeat (5) begin @(posedge clk); #1; end
    check_val("t5_err",    128'(perr), 128'd1);
    check_val("t5_no_wr",  128'(wr_q.size() - w0), 128'd0);
    repeat (10) begin @(posedge clk); #1; end
    check_val("t5_err_sticky", 128'(perr), 128'd1);

    // Reset after three beats held in the FIFO by a conflict
    do_reset();
    check_val("t6_err_clr", 128'(perr), 128'd0);
    unread = 12'd0; base = 24'h000300; en = 1'b1;
    do_burst(1, 3, 0, 3, 1'b0, 128'h33, fvc);
    check_val("t6_busy_pre", 128'(busy), 128'd1);
    rst_n = 1'b0; en = 1'b0;
    #1;
    check_val("t6_req",   128'(req),     128'd0);
    check_val("t6_addr",  128'(addr),    128'd0);
    check_val("t6_op_en", 128'(op_en),   128'd0);
    check_val("t6_rw",    128'(rw),      128'd0);
    check_val("t6_data",  l2_data,       128'd0);
    check_val("t6_busy",  128'(busy),    128'd0);
    check_val("t6_bw",    128'(bw),      128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = wr_q.size(); r0 = req_q.size();
    repeat (10) begin @(posedge clk); #1; end
    check_val("t6_no_wr",   128'(wr_q.size() - w0),  128'd0);
    check_val("t6_no_req",  128'(req_q.size() - r0), 128'd0);
    check_val("t6_bw_post", 128'(bw),   128'd0);
    check_val("t6_idle",    128'(busy), 128'd0);

    check_val("rw_follows_en", 128'(rw_viol), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_l2_ddr_refill_ctrl
`default_nettype wire
